// File: rtl/spi_master_if.sv
// Host-side request/response bundle for the SPI master: transfer start,
// speed select, tx/rx bytes, chip-select write strobe and status.
interface spi_master_if;
    logic       start;
    logic       slow;
    logic [7:0] tx;
    logic       csWr;
    logic       csD;
    logic [7:0] rx;
    logic       busy;
    logic       done;

    modport master (
        output start, slow, tx, csWr, csD,
        input  rx, busy, done
    );

    modport slave (
        input  start, slow, tx, csWr, csD,
        output rx, busy, done
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 byte master for an SD card: MSB first, selectable half-period
// (fast/slow), software chip select, one-cycle done pulse per byte.
module spi_master #(
    parameter int FASTDIV = 2,
    parameter int SLOWDIV = 70
) (
    input  logic         clock,
    input  logic         reset,
    spi_master_if.slave  bus,
    output logic         cs,
    output logic         ck,
    output logic         mosi,
    input  logic         miso
);

    localparam int MAXDIV = (FASTDIV > SLOWDIV) ? FASTDIV : SLOWDIV;
    localparam int CW     = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] half_q, half_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_q, rx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cs_q, cs_d;
    logic          ck_q, ck_d;
    logic          mosi_q, mosi_d;
    logic          phaseEnd;

    // half_q holds N-1, so a phase ends when the counter reaches it
    assign phaseEnd = (cnt_q == half_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
            ck_q    <= 1'b0;
            mosi_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            ck_q    <= ck_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOW;
            LOW:     if (phaseEnd) state_d = HIGH;
            HIGH:    if (phaseEnd) state_d = (bit_q == 3'd7) ? IDLE : LOW;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        half_d  = half_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cs_d    = cs_q;
        ck_d    = ck_q;
        mosi_d  = mosi_q;
        if (!busy_q && bus.csWr) cs_d = bus.csD;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d  = 1'b1;
                    ck_d    = 1'b0;
                    mosi_d  = bus.tx[7];
                    shift_d = bus.tx;
                    cnt_d   = '0;
                    bit_d   = '0;
                    half_d  = bus.slow ? CW'(SLOWDIV - 1) : CW'(FASTDIV - 1);
                end
            end
            LOW: begin
                if (phaseEnd) begin
                    cnt_d   = '0;
                    ck_d    = 1'b1;
                    shift_d = {shift_q[6:0], miso};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (phaseEnd) begin
                    cnt_d = '0;
                    ck_d  = 1'b0;
                    // shift_q doubles as tx source (MSB) and rx sink (LSB)
                    if (bit_q == 3'd7) begin
                        mosi_d = 1'b1;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        rx_d   = shift_q;
                    end else begin
                        mosi_d = shift_q[7];
                        bit_d  = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.rx   = rx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign cs       = cs_q;
    assign ck       = ck_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: directed transfers push expected rx and
// done cycle; a forked monitor checks every done pulse against the queue.
module tb_spi_master;

    typedef struct {
        logic [7:0] rx;
        int         doneCyc;
    } expect_t;

    logic clock = 1'b0;
    logic reset;
    logic cs, ck, mosi, miso;
    int   misoMode;

    expect_t    sbQ[$];
    int         rdIdx;
    int         compared;
    int         mismatched;
    int         cyc;
    int         busyCyc, rises, minRun, maxRun, runLen;
    logic       mosiLowSeen;
    logic [7:0] mosiBits;
    logic       prevBusy, prevCk;

    spi_master_if bus();

    assign miso = (misoMode == 2) ? mosi : misoMode[0];

    spi_master #(.FASTDIV(2), .SLOWDIV(70)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .cs    (cs),
        .ck    (ck),
        .mosi  (mosi),
        .miso  (miso)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic toNeg;
        @(negedge clock);
        #1;
    endtask

    task automatic cycCounter;
        forever begin
            @(posedge clock);
            cyc++;
        end
    endtask

    task automatic recordRun(input int len);
        if (len < minRun) minRun = len;
        if (len > maxRun) maxRun = len;
    endtask

    // Per-transfer ck/mosi statistics, restarted whenever busy rises
    task automatic measureLoop;
        forever begin
            @(negedge clock);
            if (bus.busy === 1'b1) begin
                if (!prevBusy) begin
                    busyCyc = 0; rises = 0; minRun = 1000000; maxRun = 0;
                    runLen = 0; mosiLowSeen = 1'b0; mosiBits = 8'h00;
                end
                busyCyc++;
                if (runLen != 0 && ck != prevCk) begin
                    recordRun(runLen);
                    runLen = 0;
                    if (ck) begin
                        rises++;
                        mosiBits = {mosiBits[6:0], mosi};
                    end
                end
                runLen++;
                if (mosi !== 1'b1) mosiLowSeen = 1'b1;
            end else if (prevBusy) begin
                recordRun(runLen);
            end
            prevBusy = (bus.busy === 1'b1);
            prevCk   = ck;
        end
    endtask

    task automatic scoreboardMonitor;
        forever begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                if (rdIdx < sbQ.size()) begin
                    checkOutput("rx", bus.rx, sbQ[rdIdx].rx);
                    checkOutput("doneCycle", cyc, sbQ[rdIdx].doneCyc);
                    rdIdx++;
                end else begin
                    checkOutput("unexpectedDone", bus.done, 1'b0);
                end
            end
        end
    endtask

    // Drives a one-cycle start; the next clock edge is E0
    task automatic applyStimulus(input logic [7:0] txv, input logic slowv, input logic expectDone,
                                 input logic [7:0] expRx, input int n, input logic wrCs, input logic csv);
        expect_t e;
        e.rx      = expRx;
        e.doneCyc = cyc + 1 + 16 * n;
        if (expectDone) sbQ.push_back(e);
        bus.start = 1'b1;
        bus.tx    = txv;
        bus.slow  = slowv;
        bus.csWr  = wrCs;
        bus.csD   = csv;
        toNeg;
        bus.start = 1'b0;
        bus.csWr  = 1'b0;
        bus.csD   = 1'b1;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.done !== 1'b1 && n < budget);
        if (bus.done !== 1'b1) checkOutput("doneTimeout", bus.done, 1'b1);
        #1;
    endtask

    task automatic checkXfer(input string tag, input int n, input logic [7:0] txv);
        checkOutput({tag, "_busyCycles"}, busyCyc, 16 * n);
        checkOutput({tag, "_ckRises"}, rises, 8);
        checkOutput({tag, "_minPhase"}, minRun, n);
        checkOutput({tag, "_maxPhase"}, maxRun, n);
        checkOutput({tag, "_mosiBits"}, mosiBits, txv);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_cs"}, cs, 1'b1);
        checkOutput({tag, "_ck"}, ck, 1'b0);
        checkOutput({tag, "_mosi"}, mosi, 1'b1);
        checkOutput({tag, "_busy"}, bus.busy, 1'b0);
        checkOutput({tag, "_done"}, bus.done, 1'b0);
        checkOutput({tag, "_rx"}, bus.rx, 8'h00);
    endtask

    initial begin
        cyc = 0; compared = 0; mismatched = 0; rdIdx = 0;
        busyCyc = 0; rises = 0; minRun = 0; maxRun = 0; runLen = 0;
        mosiLowSeen = 1'b0; mosiBits = 8'h00; prevBusy = 1'b0; prevCk = 1'b0;
        reset = 1'b1; misoMode = 0;
        bus.start = 1'b0; bus.slow = 1'b0; bus.tx = 8'h00; bus.csWr = 1'b0; bus.csD = 1'b1;
        fork
            cycCounter();
            measureLoop();
            scoreboardMonitor();
        join_none

        repeat (3) toNeg;
        checkResetState("reset");
        reset = 1'b0;
        toNeg;

        misoMode = 2;
        applyStimulus(8'hA5, 1'b0, 1'b1, 8'hA5, 2, 1'b0, 1'b1);
        waitDone(100);
        checkXfer("loopA5", 2, 8'hA5);
        toNeg;

        misoMode = 0;
        applyStimulus(8'hFF, 1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b1);
        waitDone(100);
        checkXfer("missoZero", 2, 8'hFF);
        checkOutput("ffMosiLow", mosiLowSeen, 1'b0);
        toNeg;

        misoMode = 1;
        applyStimulus(8'h00, 1'b0, 1'b1, 8'hFF, 2, 1'b0, 1'b1);
        waitDone(100);
        checkXfer("misoOne", 2, 8'h00);
        toNeg;

        misoMode = 2;
        applyStimulus(8'h3C, 1'b1, 1'b1, 8'h3C, 70, 1'b0, 1'b1);
        repeat (100) toNeg;
        bus.slow = 1'b0;
        repeat (300) toNeg;
        bus.slow = 1'b1;
        repeat (300) toNeg;
        bus.slow = 1'b0;
        waitDone(1000);
        checkXfer("slow3C", 70, 8'h3C);
        toNeg;

        applyStimulus(8'h5A, 1'b0, 1'b1, 8'h5A, 2, 1'b0, 1'b1);
        repeat (4) toNeg;
        bus.start = 1'b1; bus.tx = 8'hFF; bus.csWr = 1'b1; bus.csD = 1'b0;
        toNeg;
        bus.start = 1'b0; bus.csWr = 1'b0; bus.csD = 1'b1;
        checkOutput("csWhileBusy", cs, 1'b1);
        waitDone(100);
        checkXfer("ignore5A", 2, 8'h5A);
        checkOutput("csAfterIgnore", cs, 1'b1);
        repeat (40) toNeg;

        bus.csWr = 1'b1; bus.csD = 1'b0;
        toNeg;
        bus.csWr = 1'b0; bus.csD = 1'b1;
        checkOutput("csLoad", cs, 1'b0);
        applyStimulus(8'h96, 1'b0, 1'b0, 8'h00, 2, 1'b0, 1'b1);
        repeat (9) toNeg;
        checkOutput("busyBeforeReset", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        checkResetState("midReset");
        toNeg;
        toNeg;
        reset = 1'b0;
        repeat (60) toNeg;
        checkOutput("idleAfterReset", bus.busy, 1'b0);
        applyStimulus(8'hC3, 1'b0, 1'b1, 8'hC3, 2, 1'b0, 1'b1);
        waitDone(100);
        checkXfer("afterResetC3", 2, 8'hC3);
        toNeg;

        applyStimulus(8'h81, 1'b0, 1'b1, 8'h81, 2, 1'b1, 1'b0);
        checkOutput("csAtE0", cs, 1'b0);
        checkOutput("busyAtE0", bus.busy, 1'b1);
        waitDone(100);
        checkOutput("busyDoneCycle", bus.busy, 1'b0);
        applyStimulus(8'h7E, 1'b0, 1'b1, 8'h7E, 2, 1'b0, 1'b1);
        checkOutput("b2bBusy", bus.busy, 1'b1);
        checkOutput("b2bCk", ck, 1'b0);
        waitDone(100);
        checkXfer("b2b7E", 2, 8'h7E);
        checkOutput("csHeld", cs, 1'b0);
        repeat (10) toNeg;
        checkOutput("allDonesSeen", rdIdx, sbQ.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter FASTDIV, default 2, meaning SPI half-period in clock cycles in fast mode (56 MHz -> 14 MHz ck).
REQ-002 SHALL have parameter SLOWDIV, default 70, meaning SPI half-period in clock cycles in slow mode (56 MHz -> 400 kHz ck, SD init).
REQ-003 SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin an 8-bit transfer.
REQ-006 SHALL have port slow, input, 1, speed select sampled at start; 1 = SLOWDIV, 0 = FASTDIV.
REQ-007 SHALL have port tx, input, 8, byte to shift out, sampled at start.
REQ-008 SHALL have port csWr, input, 1, one-cycle strobe loading chip-select from csD.
REQ-009 SHALL have port csD, input, 1, new chip-select level (1 = deselected).
REQ-010 SHALL have port rx, output, 8, last received byte.
REQ-011 SHALL have port busy, output, 1, transfer in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at transfer completion.
REQ-013 SHALL have ports cs, ck, mosi (outputs, 1 each) and miso (input, 1) to the SD card SPI responder.

Function
REQ-014 SHALL implement SPI mode 0: ck idles low, MSB first, miso sampled on ck rising edge, mosi changes on ck falling edge.
REQ-015 SHALL use states IDLE, LOW, HIGH; IDLE->LOW on start, LOW->HIGH and HIGH->LOW after N cycles each, HIGH->IDLE after the 8th high phase.
REQ-016 SHALL latch N = (slow ? SLOWDIV : FASTDIV) at the start edge; changes to slow during a transfer have no effect.
REQ-017 SHALL, on the edge where start=1 in IDLE (edge E0), set busy=1, ck=0, mosi=tx[7], load shift register with tx.
REQ-018 SHALL hold each ck phase for exactly N clock cycles via a half-period counter wide enough for max(FASTDIV,SLOWDIV)-1.
REQ-019 SHALL, on each LOW->HIGH edge, drive ck=1 and shift miso into the receive LSB.
REQ-020 SHALL, on each HIGH->LOW edge (except the last), drive ck=0 and present the next tx bit on mosi.
REQ-021 SHALL, at edge E0+16N, drive ck=0, mosi=1, busy=0, done=1 for exactly one cycle, and update rx with the 8 received bits (first bit in rx[7]).
REQ-022 SHALL hold mosi=1 and ck=0 whenever IDLE.
REQ-023 SHALL ignore start while busy=1; no restart, no queueing.
REQ-024 SHALL accept a new start on the cycle done=1 (IDLE already), giving back-to-back transfers with no idle gap beyond that cycle.
REQ-025 SHALL update cs<=csD on csWr only while busy=0; csWr while busy is ignored.
REQ-026 SHALL, when start and csWr coincide in IDLE, apply both on the same edge (cs changes at E0).
REQ-027 SHALL keep rx stable between done pulses.

Reset
REQ-028 SHALL, on reset assertion at any time including mid-transfer, immediately force state IDLE, cs=1, ck=0, mosi=1, busy=0, done=0, rx=8'h00, counter=0.
REQ-029 SHALL, after reset release, require a new start; no partial transfer resumes and no done is produced for the aborted byte.

Verification
REQ-030 SHALL verify loopback (mosi->miso), FASTDIV=2, start with tx=8'hA5 -> busy high 32 cycles, 8 ck pulses of 4-cycle period, done at E0+32, rx=8'hA5.
REQ-031 SHALL verify miso tied 0, tx=8'hFF -> mosi high all 8 bits, rx=8'h00; then miso tied 1, tx=8'h00 -> rx=8'hFF.
REQ-032 SHALL verify slow=1, tx=8'h3C -> ck high/low 70 cycles each, done at E0+1120, slow toggled mid-transfer has no effect.
REQ-033 SHALL verify start pulsed at E0+5 during a transfer and csWr(csD=0) while busy -> ignored; cs stays 1, single done.
REQ-034 SHALL verify reset asserted at E0+10 -> outputs immediately at reset values, no done after release; next start completes normally.
REQ-035 SHALL verify csWr(csD=0)+start same cycle -> cs=0 at E0; start on done cycle -> second transfer begins with ck low, busy continuous except that cycle.
